// File: rtl/shared_dm_arbiter.sv
// Shared data-memory arbiter: NUM_C cores plus the host com port onto one DM port.
// Reads return through a tag pipeline that steers DM_out back to the requester.

module dm_rd_lane #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hit,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] data,
  output logic              valid
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= hit;
      if (hit) data <= rdata;
    end
  end
endmodule

module shared_dm_arbiter #(
  parameter int NUM_C  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               status,
  input  logic [DATA_W-1:0]        com_data_in,
  input  logic [ADDR_W-1:0]        com_addr,
  input  logic                     com_wr_en,
  input  logic                     com_rd_en,
  output logic [DATA_W-1:0]        com_data_out,
  output logic                     com_valid,
  input  logic [NUM_C-1:0]         core_req,
  input  logic [NUM_C-1:0]         core_wr_en,
  input  logic [NUM_C*ADDR_W-1:0]  core_addr,
  input  logic [NUM_C*DATA_W-1:0]  core_data_in,
  output logic [NUM_C-1:0]         core_grant,
  output logic [NUM_C*DATA_W-1:0]  core_data_out,
  output logic [NUM_C-1:0]         core_valid,
  output logic [ADDR_W-1:0]        DM_addr,
  output logic [DATA_W-1:0]        DM_data_in,
  output logic                     DM_write_en,
  input  logic [DATA_W-1:0]        DM_out
);
  localparam int IDX_W = $clog2(NUM_C);

  typedef enum logic [1:0] {
    ST_HOST   = 2'b00,
    ST_RUN    = 2'b01,
    ST_RUN_HP = 2'b10,
    ST_HALT   = 2'b11
  } mode_e;

  typedef struct packed {
    logic              vld;
    logic              host;
    logic [IDX_W-1:0]  idx;
  } tag_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              wr;
  } req_t;

  mode_e                        mode;
  logic [NUM_C-1:0][ADDR_W-1:0] c_addr;
  logic [NUM_C-1:0][DATA_W-1:0] c_wdata;
  logic [NUM_C-1:0][DATA_W-1:0] c_rdata;
  logic [IDX_W-1:0]             rr_ptr, rr_idx, cand;
  logic                         rr_hit, host_act, host_own, core_own;
  req_t                         req_sel;
  tag_t                         issue_tag, out_tag;
  tag_t                         tag_pipe [1:RD_LAT];
  logic [NUM_C-1:0]             core_hit;
  logic                         com_hit;

  assign mode     = mode_e'(status);
  assign c_addr   = core_addr;
  assign c_wdata  = core_data_in;
  assign host_act = com_wr_en | com_rd_en;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_C.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = '0;
    for (int k = 0; k < NUM_C; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_C);
      if (!rr_hit && core_req[cand]) begin
        rr_hit = 1'b1;
        rr_idx = cand;
      end
    end
  end

  // Ownership is suppressed during reset so nothing reaches DM before rr_ptr is valid.
  always_comb begin
    host_own = 1'b0;
    core_own = 1'b0;
    if (rst_n) begin
      case (mode)
        ST_HOST:   host_own = host_act;
        ST_RUN:    core_own = rr_hit;
        ST_RUN_HP: begin
          host_own = host_act;
          core_own = !host_act && rr_hit;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_sel    = '0;
    issue_tag  = '0;
    core_grant = '0;
    if (host_own) begin
      req_sel.addr   = com_addr;
      req_sel.data   = com_data_in;
      req_sel.wr     = com_wr_en;
      issue_tag.vld  = !com_wr_en;
      issue_tag.host = 1'b1;
    end else if (core_own) begin
      core_grant[rr_idx] = 1'b1;
      req_sel.addr   = c_addr[rr_idx];
      req_sel.data   = c_wdata[rr_idx];
      req_sel.wr     = core_wr_en[rr_idx];
      issue_tag.vld  = !core_wr_en[rr_idx];
      issue_tag.idx  = rr_idx;
    end
  end

  assign DM_addr     = req_sel.addr;
  assign DM_data_in  = req_sel.data;
  assign DM_write_en = req_sel.wr;

  always_ff @(posedge clk) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (core_own)
      rr_ptr <= (rr_idx == IDX_W'(NUM_C - 1)) ? '0 : rr_idx + 1'b1;
  end

  // Tag stage RD_LAT lines up with DM_out for the read issued RD_LAT cycles earlier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 1; s <= RD_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[1] <= issue_tag;
      for (int s = 2; s <= RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign out_tag = tag_pipe[RD_LAT];
  assign com_hit = out_tag.vld & out_tag.host;

  always_comb begin
    core_hit = '0;
    if (out_tag.vld && !out_tag.host) core_hit[out_tag.idx] = 1'b1;
  end

  for (genvar i = 0; i < NUM_C; i++) begin : g_lane
    logic [DATA_W-1:0] lane_data;
    dm_rd_lane #(.DATA_W(DATA_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .hit   (core_hit[i]),
      .rdata (DM_out),
      .data  (lane_data),
      .valid (core_valid[i])
    );
    assign c_rdata[i] = lane_data;
  end

  assign core_data_out = c_rdata;

  dm_rd_lane #(.DATA_W(DATA_W)) u_com (
    .clk   (clk),
    .rst_n (rst_n),
    .hit   (com_hit),
    .rdata (DM_out),
    .data  (com_data_out),
    .valid (com_valid)
  );
endmodule

// File: tb/tb_shared_dm_arbiter.sv
// Directed bench for shared_dm_arbiter (NUM_C=4, RD_LAT=2) with a small DRAM model.
module tb_shared_dm_arbiter;
  localparam int NC = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RL = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       status;
  logic [DW-1:0]    com_data_in;
  logic [AW-1:0]    com_addr;
  logic             com_wr_en, com_rd_en;
  logic [DW-1:0]    com_data_out;
  logic             com_valid;
  logic [NC-1:0]    core_req, core_wr_en, core_grant, core_valid;
  logic [NC*AW-1:0] core_addr;
  logic [NC*DW-1:0] core_data_in, core_data_out;
  logic [AW-1:0]    DM_addr;
  logic [DW-1:0]    DM_data_in, DM_out;
  logic             DM_write_en;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shared_dm_arbiter #(.NUM_C(NC), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n), .status(status),
    .com_data_in(com_data_in), .com_addr(com_addr),
    .com_wr_en(com_wr_en), .com_rd_en(com_rd_en),
    .com_data_out(com_data_out), .com_valid(com_valid),
    .core_req(core_req), .core_wr_en(core_wr_en),
    .core_addr(core_addr), .core_data_in(core_data_in),
    .core_grant(core_grant), .core_data_out(core_data_out), .core_valid(core_valid),
    .DM_addr(DM_addr), .DM_data_in(DM_data_in), .DM_write_en(DM_write_en), .DM_out(DM_out)
  );

  // DRAM model: write at the edge, read data RL cycles after the address.
  logic [DW-1:0] mem [0:255];
  logic [AW-1:0] a1, a2;
  always @(posedge clk) begin
    if (DM_write_en) mem[DM_addr[7:0]] <= DM_data_in;
    a1 <= DM_addr;
    a2 <= a1;
  end
  assign DM_out = mem[a2[7:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fair(input logic [NC-1:0] req, input logic [NC-1:0] exp);
    core_req = req;
    #1 chk("fair_grant", 64'(core_grant), 64'(exp));
    tick();
  endtask

  initial begin
    rst_n = 1'b0; status = 2'b01;
    com_data_in = '0; com_addr = '0; com_wr_en = 1'b0; com_rd_en = 1'b0;
    core_req = '1; core_wr_en = '1;
    core_addr    = {16'h0023, 16'h0022, 16'h0021, 16'h0020};
    core_data_in = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    tick(); tick();
    chk("rst_grant",      64'(core_grant), 64'(0));
    chk("rst_dm_we",      64'(DM_write_en), 64'(0));
    chk("rst_dm_addr",    64'(DM_addr), 64'(0));
    chk("rst_core_valid", 64'(core_valid), 64'(0));
    chk("rst_com_valid",  64'(com_valid), 64'(0));
    chk("rst_core_data",  64'(core_data_out), 64'(0));
    chk("rst_com_data",   64'(com_data_out), 64'(0));

    // Round-robin after reset: 0,1,2,3,0 (all cores writing)
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_wrap_grant", 64'(core_grant), 64'(1 << (k % 4)));
      chk("rr_wrap_addr",  64'(DM_addr), 64'(16'h20 + k % 4));
      tick();
    end

    // Host mode write then read of 0x0010
    status = 2'b00; com_wr_en = 1'b1; com_addr = 16'h0010; com_data_in = 16'hBEEF;
    #1;
    chk("host_wr_we",    64'(DM_write_en), 64'(1));
    chk("host_wr_addr",  64'(DM_addr), 64'(16'h0010));
    chk("host_wr_data",  64'(DM_data_in), 64'(16'hBEEF));
    chk("host_no_grant", 64'(core_grant), 64'(0));
    tick();
    com_wr_en = 1'b0; com_rd_en = 1'b1;
    #1;
    chk("host_rd_we",    64'(DM_write_en), 64'(0));
    chk("host_rd_addr",  64'(DM_addr), 64'(16'h0010));
    chk("host_rd_grant", 64'(core_grant), 64'(0));
    tick(); com_rd_en = 1'b0;
    #1 chk("host_rd_lat1", 64'(com_valid), 64'(0));
    tick();
    #1 chk("host_rd_lat2", 64'(com_valid), 64'(0));
    tick();
    #1;
    chk("host_rd_valid", 64'(com_valid), 64'(1));
    chk("host_rd_data",  64'(com_data_out), 64'(16'hBEEF));
    tick();
    #1;
    chk("host_valid_pulse", 64'(com_valid), 64'(0));
    chk("host_data_hold",   64'(com_data_out), 64'(16'hBEEF));

    // Both strobes: a write only, no read returns
    com_wr_en = 1'b1; com_rd_en = 1'b1; com_addr = 16'h0011; com_data_in = 16'h1234;
    #1 chk("both_we", 64'(DM_write_en), 64'(1));
    tick(); com_wr_en = 1'b0; com_rd_en = 1'b0;
    tick(); tick();
    #1;
    chk("both_no_read",   64'(com_valid), 64'(0));
    chk("both_data_hold", 64'(com_data_out), 64'(16'hBEEF));
    tick();

    // Fairness, rr_ptr=1 on entry
    status = 2'b01;
    fair(4'b0101, 4'b0100);
    fair(4'b0101, 4'b0001);
    fair(4'b0101, 4'b0100);
    fair(4'b0111, 4'b0001);
    fair(4'b0111, 4'b0010);
    fair(4'b0101, 4'b0100);

    // Host priority, rr_ptr=3 on entry; host reads 0x0020 (=A000)
    status = 2'b10; core_req = 4'b0010; com_rd_en = 1'b1; com_addr = 16'h0020;
    #1;
    chk("hp_host_grant", 64'(core_grant), 64'(0));
    chk("hp_host_addr",  64'(DM_addr), 64'(16'h0020));
    chk("hp_host_we",    64'(DM_write_en), 64'(0));
    tick(); com_rd_en = 1'b0;
    #1 chk("hp_core1_grant", 64'(core_grant), 64'(4'b0010));
    tick(); core_req = 4'b1111;
    #1 chk("hp_rr_next", 64'(core_grant), 64'(4'b0100));
    tick(); core_req = 4'b0000;
    #1;
    chk("hp_host_valid", 64'(com_valid), 64'(1));
    chk("hp_host_data",  64'(com_data_out), 64'(16'hA000));
    tick();

    // Pipelined reads; preload via host, rr_ptr=3 on entry
    status = 2'b00; com_wr_en = 1'b1;
    com_addr = 16'h0001; com_data_in = 16'h1111; tick();
    com_addr = 16'h0002; com_data_in = 16'h2222; tick();
    com_addr = 16'h0003; com_data_in = 16'h3333; tick();
    com_wr_en = 1'b0; status = 2'b01; core_wr_en = '0;
    core_addr = {16'h0003, 16'h0002, 16'h0002, 16'h0001};
    core_req = 4'b0001;
    #1 chk("pl_grant0", 64'(core_grant), 64'(4'b0001));
    tick(); core_req = 4'b0010;
    #1 chk("pl_grant1", 64'(core_grant), 64'(4'b0010));
    tick(); core_req = 4'b1000;
    #1 chk("pl_grant3", 64'(core_grant), 64'(4'b1000));
    tick(); status = 2'b11; core_req = 4'b1111;
    #1;
    chk("halt_grant", 64'(core_grant), 64'(0));
    chk("halt_we",    64'(DM_write_en), 64'(0));
    chk("pl_v0",      64'(core_valid), 64'(4'b0001));
    chk("pl_d0",      64'(core_data_out[15:0]), 64'(16'h1111));
    tick();
    #1;
    chk("pl_v1",      64'(core_valid), 64'(4'b0010));
    chk("pl_d1",      64'(core_data_out[31:16]), 64'(16'h2222));
    chk("pl_d0_hold", 64'(core_data_out[15:0]), 64'(16'h1111));
    tick();
    #1;
    chk("pl_v3", 64'(core_valid), 64'(4'b1000));
    chk("pl_d3", 64'(core_data_out[63:48]), 64'(16'h3333));
    tick();
    #1 chk("pl_idle", 64'(core_valid), 64'(0));

    // Reset mid-flight; rr_ptr=0 on entry
    status = 2'b01; core_req = 4'b0100;
    #1 chk("mf_grant", 64'(core_grant), 64'(4'b0100));
    tick(); core_req = 4'b0000; rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    #1;
    chk("mf_valid_a", 64'(core_valid), 64'(0));
    chk("mf_data_clr", 64'(core_data_out), 64'(0));
    chk("mf_com_clr",  64'(com_data_out), 64'(0));
    tick();
    #1;
    chk("mf_no_valid",     64'(core_valid), 64'(0));
    chk("mf_no_com_valid", 64'(com_valid), 64'(0));
    core_req = 4'b1111; core_wr_en = '1;
    #1 chk("mf_rr_reset", 64'(core_grant), 64'(4'b0001));
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
